dft_frame_loader: RTL



---
 rtl/dft_pkg.sv | 14 +
 rtl/window_shift_reg.sv | 31 +++
 rtl/dft_frame_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dft_pkg.sv
// Shared types and widths for the DFT front end.
// Holds the loader state enum and the word/frame-counter widths.
package dft_pkg;

    localparam int WORD_W      = 32;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/window_shift_reg.sv
// SIZE-deep sample window; [0] oldest, [SIZE-1] newest.
// Ports: clk, rst (sync clear), shiftEn, din in; data[0:SIZE-1] out.
module window_shift_reg #(
    parameter int SIZE  = 28,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shiftEn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data [SIZE]
);

    logic [WIDTH-1:0] win_q [SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                win_q[i] <= '0;
            end
        end else if (shiftEn) begin
            for (int i = 0; i < SIZE - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[SIZE-1] <= din;
        end
    end

    assign data = win_q;

endmodule

// File: rtl/dft_frame_loader.sv
// Serial-to-window loader feeding the weighted-sum tree, one result per launch.
// Ports: clk, rst, flush, sampleValid/sample/sampleReady, data, dataIn/dataOut/result, outValid/outResult, frameCnt.
module dft_frame_loader
    import dft_pkg::*;
#(
    parameter int SIZE  = 28,
    parameter int HOP   = 14,
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   sampleValid,
    input  logic [WIDTH-1:0]       sample,
    output logic                   sampleReady,
    output logic [WIDTH-1:0]       data [SIZE],
    output logic                   dataIn,
    input  logic                   dataOut,
    input  logic [WIDTH-1:0]       result,
    output logic                   outValid,
    output logic [WIDTH-1:0]       outResult,
    output logic [FRAME_CNT_W-1:0] frameCnt
);

    localparam int CNT_W = $clog2(SIZE + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       need;
    logic                   primed_q, primed_d;
    logic                   dataIn_q;
    logic                   outValid_q, outValid_d;
    logic [WIDTH-1:0]       outResult_q, outResult_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   accept;

    // Ready depends on state only, so upstream never sees a comb loop.
    assign sampleReady = (state_q == FILL);
    assign accept      = sampleReady && sampleValid;
    assign need        = primed_q ? CNT_W'(HOP) : CNT_W'(SIZE);
    assign cnt_inc     = cnt_q + 1'b1;

    window_shift_reg #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_win (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (accept),
        .din     (sample),
        .data    (data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        outValid_d  = 1'b0;
        outResult_d = outResult_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            FILL: begin
                if (flush) begin
                    // Stale history: restart the count, keeping a coincident sample.
                    primed_d = 1'b0;
                    cnt_d    = accept ? CNT_W'(1) : '0;
                end else if (accept) begin
                    if (cnt_inc == need) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        primed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    primed_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = GAP;
                end else if (dataOut) begin
                    outValid_d  = 1'b1;
                    outResult_d = result;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = GAP;
                end
            end
            GAP: begin
                // One idle cycle so the tree sees a fresh launch edge.
                state_d = FILL;
                if (flush) begin
                    primed_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d  = FILL;
                cnt_d    = '0;
                primed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            dataIn_q    <= 1'b0;
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            dataIn_q    <= (state_d == RUN);
            outValid_q  <= outValid_d;
            outResult_q <= outResult_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dataIn    = dataIn_q;
    assign outValid  = outValid_q;
    assign outResult = outResult_q;
    assign frameCnt  = frame_cnt_q;

endmodule
